// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//
// Single-transfer APB initiator. A command accepted on the valid/ready
// interface becomes one APB SETUP cycle followed by one or more ACCESS cycles.
// Exactly one response strobe is returned per accepted command. A wait-state
// timeout aborts the transfer if the slave holds pready low for too long.
//
// Parameters:
//   ADDR_WIDTH     - width of cmd_addr / paddr
//   DATA_WIDTH     - width of write and read data
//   TIMEOUT_CYCLES - ACCESS cycles with pready low before abort (0 = never)
//
// Ports:
//   pclk, presetn            - APB clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      - command handshake
//   cmd_write/addr/wdata     - command direction, address, write data
//   rsp_valid                - one-cycle response strobe
//   rsp_rdata/err/timeout    - response payload, held until next response
//   psel/penable/pwrite      - APB control
//   paddr/pwdata             - APB address and write data
//   prdata/pready/pslverr    - APB slave response
// -----------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    // The counter holds the number of ACCESS cycles already completed, so the
    // abort fires while it still reads TIMEOUT_CYCLES-1 and it never wraps.
    localparam logic [CNT_W-1:0] LAST_CNT =
        TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    // Single registered FSM: every output is a flop, so the APB and response
    // signals change only on pclk edges (or immediately on reset).
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            // The response strobe lasts one cycle; the payload is held.
            rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state     <= SETUP;
                        cmd_ready <= 1'b0;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        pwrite    <= cmd_write;
                        paddr     <= cmd_addr;
                        pwdata    <= cmd_wdata;
                        wait_cnt  <= '0;
                    end
                end

                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end

                ACCESS: begin
                    // psel and penable are both high here, so pready alone
                    // qualifies the completing edge and the pslverr sample.
                    if (pready) begin
                        state       <= IDLE;
                        cmd_ready   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                    end else if (TIMEOUT_EN && (wait_cnt == LAST_CNT)) begin
                        state       <= IDLE;
                        cmd_ready   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else if (TIMEOUT_EN) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-transfer APB initiator. Converts a simple valid/ready command interface into APB SETUP/ACCESS cycles and returns one response per command.
- Drives the APB slave in the subsystem and is the RTL counterpart to the bench's APB driver.
- Adds a wait-state timeout so a hung slave cannot stall the command source.

Parameters:
ADDR_WIDTH, 8, width of cmd_addr/paddr
DATA_WIDTH, 32, width of write/read data
TIMEOUT_CYCLES, 16, max ACCESS cycles with pready low before abort; 0 disables timeout

Ports:
pclk  input  1  APB clock; all logic on rising edge
presetn  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  bridge can accept a command
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_WIDTH  transfer address
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle response strobe
rsp_rdata  output  DATA_WIDTH  read data (0 for writes/aborts)
rsp_err  output  1  pslverr seen or timeout
rsp_timeout  output  1  transfer aborted by timeout
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDR_WIDTH  APB address
pwdata  output  DATA_WIDTH  APB write data
prdata  input  DATA_WIDTH  APB read data
pready  input  1  APB ready
pslverr  input  1  APB error

Behaviour:
- Reset (presetn=0, async):
  - State=IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0.
  - cmd_ready=1 once presetn=1.
  - Reset mid-transfer drops psel/penable immediately. No response is issued.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - cmd_ready=1, psel=0, penable=0.
  - On cmd_valid&&cmd_ready: latch cmd_write/addr/wdata into pwrite/paddr/pwdata, go to SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0, cmd_ready=0; next state ACCESS.
- ACCESS:
  - psel=1, penable=1; wait counter increments each ACCESS cycle.
  - If pready=1: complete. Return to IDLE with psel=penable=0, rsp_valid=1 for one cycle, rsp_err=pslverr, rsp_timeout=0.
    - Read: rsp_rdata=prdata sampled at the completing edge.
    - Write: rsp_rdata=0.
  - If pready=0 and TIMEOUT_CYCLES≠0 and this is ACCESS cycle number TIMEOUT_CYCLES: abort. Return to IDLE, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Otherwise remain in ACCESS.
- pready=1 on the same cycle the timeout would fire: completion wins, no timeout.
- pslverr is sampled only when psel&penable&pready; ignored otherwise.
- paddr/pwrite/pwdata stay stable from SETUP through the end of ACCESS and hold their last values in IDLE. No X-propagation.
- Latency:
  - cmd handshake at edge N → SETUP during N→N+1 → ACCESS from N+1.
  - Zero-wait slave: rsp_valid asserted in the cycle after edge N+2.
  - Minimum 3 cycles per transfer. No back-to-back pipelining; cmd_ready is high only in IDLE, including the rsp_valid cycle.
- rsp_rdata/rsp_err/rsp_timeout hold until the next response; they are valid only while rsp_valid=1.
- cmd_valid while not ready: ignored. The command source must hold the request.
- Wait counter width is clog2(TIMEOUT_CYCLES+1), minimum 1. It resets to 0 on entering SETUP; there is no wrap because the abort fires first.

Test Plan:
1. Write addr=0x10 data=0xDEADBEEF, slave pready=1 immediately → psel high 2 cycles, penable high 1 cycle with pwrite=1/paddr=0x10; rsp_valid=1, rsp_err=0, rsp_rdata=0.
2. Read addr=0x10 after test 1, slave inserts 3 wait states → ACCESS lasts 4 cycles, paddr stable; rsp_rdata=0xDEADBEEF, rsp_err=0.
3. Read addr=0xFF with slave returning pslverr=1 on completion → rsp_valid=1, rsp_err=1, rsp_timeout=0.
4. Write with pready held low (TIMEOUT_CYCLES=16) → exactly 16 ACCESS cycles, then psel=0, rsp_err=1, rsp_timeout=1; next command accepted normally.
5. pready rises on ACCESS cycle 16 → normal completion, rsp_timeout=0.
6. Assert presetn=0 mid-ACCESS → psel/penable/rsp_* go 0 asynchronously, no rsp_valid; after release cmd_ready=1 and a fresh read completes correctly.
